// File: rtl/chacha_pkg.sv
// Shared definitions for the ChaCha inverse-quarterround block:
// FSM state encoding, word width, rotate amounts and a rotate-right helper.
package chacha_pkg;

  localparam int unsigned WORD_W = 32;

  // Rotate amounts of the forward quarterround, in forward order.
  localparam int unsigned ROT_16 = 16;
  localparam int unsigned ROT_12 = 12;
  localparam int unsigned ROT_8  = 8;
  localparam int unsigned ROT_7  = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                             input int unsigned       n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

endpackage

// File: rtl/chacha_inv_qr_step.sv
// One inverse quarterround sub-step (combinational).
// Ports:
//   step        - which of the four inverse sub-steps to apply (0..3)
//   wa..wd      - current working words
//   na..nd      - working words after the sub-step
// Each sub-step undoes one "x += y; z ^= x; z <<<= r" line of the forward
// quarterround, last line first. All right-hand sides use the incoming words.
module chacha_inv_qr_step
  import chacha_pkg::*;
(
  input  logic [1:0]        step,
  input  logic [WORD_W-1:0] wa,
  input  logic [WORD_W-1:0] wb,
  input  logic [WORD_W-1:0] wc,
  input  logic [WORD_W-1:0] wd,
  output logic [WORD_W-1:0] na,
  output logic [WORD_W-1:0] nb,
  output logic [WORD_W-1:0] nc,
  output logic [WORD_W-1:0] nd
);

  always_comb begin
    na = wa;
    nb = wb;
    nc = wc;
    nd = wd;
    case (step)
      2'd0: begin
        nb = rotr(wb, ROT_7) ^ wc;
        nc = wc - wd;
      end
      2'd1: begin
        nd = rotr(wd, ROT_8) ^ wa;
        na = wa - wb;
      end
      2'd2: begin
        nb = rotr(wb, ROT_12) ^ wc;
        nc = wc - wd;
      end
      default: begin
        nd = rotr(wd, ROT_16) ^ wa;
        na = wa - wb;
      end
    endcase
  end

endmodule

// File: rtl/chacha_inv_qr.sv
// ChaCha inverse quarterround engine: accepts four quarterround output words,
// applies ITER inverse quarterrounds (four cycles each) and presents the
// recovered words with a valid/ready handshake.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   in_valid / in_ready   - request handshake (in_ready only in IDLE)
//   a_prim..d_prim        - words to invert, captured on the request handshake
//   out_valid / out_ready - result handshake
//   a..d                  - recovered words, stable while out_valid && !out_ready
//   done_cnt              - output handshake counter, present only when
//                           CHACHA_INV_QR_STATS_EN is defined
module chacha_inv_qr
  import chacha_pkg::*;
#(
  parameter int unsigned ITER = 1
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] a_prim,
  input  logic [WORD_W-1:0] b_prim,
  input  logic [WORD_W-1:0] c_prim,
  input  logic [WORD_W-1:0] d_prim,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] a,
  output logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] c,
  output logic [WORD_W-1:0] d
`ifdef CHACHA_INV_QR_STATS_EN
  ,
  output logic [15:0]       done_cnt
`endif
);

  state_e            state_q, state_d;
  logic [1:0]        step_q, step_d;
  logic [7:0]        iter_q, iter_d;
  logic [WORD_W-1:0] wa_q, wa_d, wb_q, wb_d, wc_q, wc_d, wd_q, wd_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic [WORD_W-1:0] na, nb, nc, nd;

  chacha_inv_qr_step u_step (
    .step (step_q),
    .wa   (wa_q),
    .wb   (wb_q),
    .wc   (wc_q),
    .wd   (wd_q),
    .na   (na),
    .nb   (nb),
    .nc   (nc),
    .nd   (nd)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    iter_d  = iter_q;
    wa_d    = wa_q;
    wb_d    = wb_q;
    wc_d    = wc_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE: begin
        // in_ready_q gating keeps the post-reset cycle from accepting.
        if (in_valid && in_ready_q) begin
          wa_d    = a_prim;
          wb_d    = b_prim;
          wc_d    = c_prim;
          wd_d    = d_prim;
          step_d  = 2'd0;
          iter_d  = 8'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        wa_d   = na;
        wb_d   = nb;
        wc_d   = nc;
        wd_d   = nd;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          iter_d = iter_q + 8'd1;
          if (iter_q == 8'(ITER - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      step_q      <= '0;
      iter_q      <= '0;
      wa_q        <= '0;
      wb_q        <= '0;
      wc_q        <= '0;
      wd_q        <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      iter_q      <= iter_d;
      wa_q        <= wa_d;
      wb_q        <= wb_d;
      wc_q        <= wc_d;
      wd_q        <= wd_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign a         = wa_q;
  assign b         = wb_q;
  assign c         = wc_q;
  assign d         = wd_q;

`ifdef CHACHA_INV_QR_STATS_EN
  logic [15:0] done_cnt_q, done_cnt_d;

  always_comb begin
    done_cnt_d = done_cnt_q;
    if (out_valid_q && out_ready) begin
      done_cnt_d = done_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_cnt_q <= '0;
    end else begin
      done_cnt_q <= done_cnt_d;
    end
  end

  assign done_cnt = done_cnt_q;
`endif

endmodule

// File: doc/chacha_inv_qr.md
CHACHA_INV_QR -- requirements
Module: chacha_inv_qr

Interface
REQ-001 SHALL have parameter: ITER, default 1, number of back-to-back inverse quarterrounds applied per request (legal 1..255).
REQ-002 SHALL have port: clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: in_valid  input  1; in_ready  output  1; request handshake.
REQ-005 SHALL have ports: a_prim, b_prim, c_prim, d_prim  input  32 each  quarterround output words to invert.
REQ-006 SHALL have ports: out_valid  output  1; out_ready  input  1; result handshake.
REQ-007 SHALL have ports: a, b, c, d  output  32 each  recovered quarterround input words.

Function
REQ-008 SHALL implement FSM states IDLE, RUN, DONE; transfer occurs when valid and ready are both high on a rising edge.
REQ-009 SHALL assert in_ready only in IDLE; in IDLE with in_valid=1, capture a_prim..d_prim into working registers wa..wd, clear step=0 and iter=0, go to RUN.
REQ-010 SHALL in RUN perform one inverse sub-step per cycle, selected by 2-bit step; all arithmetic mod 2^32, rotr = rotate right.
REQ-011 SHALL step 0: wb <= rotr(wb,7) ^ wc; wc <= wc - wd.
REQ-012 SHALL step 1: wd <= rotr(wd,8) ^ wa; wa <= wa - wb.
REQ-013 SHALL step 2: wb <= rotr(wb,12) ^ wc; wc <= wc - wd.
REQ-014 SHALL step 3: wd <= rotr(wd,16) ^ wa; wa <= wa - (rotr(wb,12) ^ wc as computed in step 2, i.e. current wb).
REQ-015 SHALL use, in every sub-step, register values from the start of that cycle for all right-hand sides.
REQ-016 SHALL after step 3 increment iter; if iter+1 == ITER go to DONE, else step wraps to 0 and RUN continues.
REQ-017 SHALL give latency exactly 4*ITER cycles from input handshake edge to first cycle out_valid=1.
REQ-018 SHALL in DONE drive out_valid=1 and a..d = wa..wd, holding them stable while out_ready=0.
REQ-019 SHALL in DONE with out_ready=1 return to IDLE on that edge; in_ready rises the following cycle (no same-cycle accept).
REQ-020 SHALL ignore in_valid and input words outside IDLE; changes there never affect the result.
REQ-021 SHALL guarantee chacha_inv_qr(QR(x)) == x for any 128-bit x with ITER=1.

Reset
REQ-022 SHALL on reset force state IDLE, step=0, iter=0, wa..wd=0, out_valid=0, in_ready=0 during reset cycle, 1 the cycle after.
REQ-023 SHALL abort any operation in RUN or DONE on reset with no output handshake generated.

Configuration
REQ-024 SHALL, with macro CHACHA_INV_QR_STATS_EN defined, add output done_cnt (16 bit) incrementing on each output handshake, wrapping 0xFFFF->0x0000, cleared by reset.
REQ-025 SHALL, without CHACHA_INV_QR_STATS_EN, omit done_cnt port and counter entirely; all other behaviour identical.

Structure
REQ-026 SHALL place FSM state enum (IDLE/RUN/DONE), rotate amounts (16,12,8,7) and word width 32 in shared package chacha_pkg.
REQ-027 SHALL isolate the four sub-step equations in one combinational sub-module chacha_inv_qr_step (inputs step, wa..wd; outputs next wa..wd).

Verification
REQ-028 SHALL cover RFC 7539 2.1.1: inputs ea2a92f4, cb1cf8ce, 4581472e, 5881c4bb, ITER=1 -> a..d = 11111111, 01020304, 9b8d6f43, 01234567 after exactly 4 cycles.
REQ-029 SHALL cover backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and a..d stable, in_ready=0 throughout, release -> IDLE next cycle.
REQ-030 SHALL cover ITER=3 with random x: input QR(QR(QR(x))) -> output x after exactly 12 cycles.
REQ-031 SHALL cover reset asserted in RUN at step 2 -> next cycle out_valid=0, a..d=0, following cycle in_ready=1; new request then completes correctly.
REQ-032 SHALL cover input toggling during RUN (in_valid=1, words changing) -> result equals inverse of originally captured words.
REQ-033 SHALL cover, with CHACHA_INV_QR_STATS_EN, 3 consecutive transactions -> done_cnt=3; preload-style 65536 transactions -> done_cnt wraps to 0.
